// File: rtl/stack_sequencer.sv
// Stack push/pop sequencer: turns pre-decoded STACK_* masks into 16-bit bus cycles at SS:SP.
module stack_sequencer #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned SEG_SHIFT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       push_mask,
    input  logic [15:0]       pop_mask,
    input  logic [15:0]       sp_in,
    input  logic [15:0]       ss_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        reg_sel,
    input  logic [15:0]       reg_rdata,
    output logic              reg_we,
    output logic [3:0]        reg_wr_sel,
    output logic [15:0]       reg_wr_data,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              sp_we,
    output logic [15:0]       sp_out
);

    localparam int unsigned SUM_W = 16 + SEG_SHIFT + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_POP      = 3'd1;
    localparam logic [2:0] S_PUSH_DEC = 3'd2;
    localparam logic [2:0] S_PUSH     = 3'd3;
    localparam logic [2:0] S_FIN      = 3'd4;

    localparam logic [3:0] SP_IDX = 4'd4;

    logic [2:0]        state_q, state_d;
    logic [15:0]       push_q, push_d;
    logic [15:0]       pop_q, pop_d;
    logic [15:0]       sp_q, sp_d;
    logic [15:0]       orig_sp_q, orig_sp_d;
    logic [15:0]       ss_q, ss_d;
    logic [3:0]        cur_idx_q, cur_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        reg_sel_q, reg_sel_d;
    logic              reg_we_q, reg_we_d;
    logic [3:0]        reg_wr_sel_q, reg_wr_sel_d;
    logic [15:0]       reg_wr_data_q, reg_wr_data_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              sp_we_q, sp_we_d;
    logic [15:0]       sp_out_q, sp_out_d;

    // Lowest set bit: pop order.
    function automatic logic [3:0] lowest_bit(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Highest set bit: push order.
    function automatic logic [3:0] highest_bit(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Physical address ({SS,0000} + SP) truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] stack_addr(input logic [15:0] ss, input logic [15:0] sp);
        logic [SUM_W-1:0] sum;
        sum = (SUM_W'(ss) << SEG_SHIFT) + SUM_W'(sp);
        return ADDR_W'(sum);
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        push_d        = push_q;
        pop_d         = pop_q;
        sp_d          = sp_q;
        orig_sp_d     = orig_sp_q;
        ss_d          = ss_q;
        cur_idx_d     = cur_idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        reg_sel_d     = reg_sel_q;
        reg_we_d      = 1'b0;
        reg_wr_sel_d  = reg_wr_sel_q;
        reg_wr_data_d = reg_wr_data_q;
        mem_req_d     = mem_req_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        sp_we_d       = 1'b0;
        sp_out_d      = sp_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    push_d    = push_mask;
                    pop_d     = pop_mask;
                    sp_d      = sp_in;
                    orig_sp_d = sp_in;
                    ss_d      = ss_in;
                    busy_d    = 1'b1;
                    if (pop_mask != 16'd0) begin
                        state_d    = S_POP;
                        cur_idx_d  = lowest_bit(pop_mask);
                        mem_req_d  = 1'b1;
                        mem_wr_d   = 1'b0;
                        mem_addr_d = stack_addr(ss_in, sp_in);
                    end else if (push_mask != 16'd0) begin
                        state_d   = S_PUSH_DEC;
                        reg_sel_d = highest_bit(push_mask);
                    end else begin
                        state_d  = S_FIN;
                        done_d   = 1'b1;
                        sp_we_d  = 1'b1;
                        sp_out_d = sp_in;
                    end
                end
            end
            S_POP: begin
                if (mem_ack) begin
                    reg_we_d      = (cur_idx_q != SP_IDX);
                    reg_wr_sel_d  = cur_idx_q;
                    reg_wr_data_d = mem_rdata;
                    sp_d          = sp_q + 16'd2;
                    pop_d         = pop_q & ~(16'd1 << cur_idx_q);
                    mem_req_d     = 1'b0;
                    if (pop_d != 16'd0) begin
                        cur_idx_d  = lowest_bit(pop_d);
                        mem_req_d  = 1'b1;
                        mem_wr_d   = 1'b0;
                        mem_addr_d = stack_addr(ss_q, sp_d);
                    end else if (push_q != 16'd0) begin
                        state_d   = S_PUSH_DEC;
                        reg_sel_d = highest_bit(push_q);
                    end else begin
                        state_d  = S_FIN;
                        done_d   = 1'b1;
                        sp_we_d  = 1'b1;
                        sp_out_d = sp_d;
                    end
                end
            end
            S_PUSH_DEC: begin
                sp_d        = sp_q - 16'd2;
                cur_idx_d   = reg_sel_q;
                mem_req_d   = 1'b1;
                mem_wr_d    = 1'b1;
                mem_addr_d  = stack_addr(ss_q, sp_d);
                mem_wdata_d = (reg_sel_q == SP_IDX) ? orig_sp_q : reg_rdata;
                state_d     = S_PUSH;
            end
            S_PUSH: begin
                if (mem_ack) begin
                    push_d    = push_q & ~(16'd1 << cur_idx_q);
                    mem_req_d = 1'b0;
                    if (push_d != 16'd0) begin
                        state_d   = S_PUSH_DEC;
                        reg_sel_d = highest_bit(push_d);
                    end else begin
                        state_d  = S_FIN;
                        done_d   = 1'b1;
                        sp_we_d  = 1'b1;
                        sp_out_d = sp_q;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            push_q        <= '0;
            pop_q         <= '0;
            sp_q          <= '0;
            orig_sp_q     <= '0;
            ss_q          <= '0;
            cur_idx_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            reg_sel_q     <= '0;
            reg_we_q      <= 1'b0;
            reg_wr_sel_q  <= '0;
            reg_wr_data_q <= '0;
            mem_req_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            sp_we_q       <= 1'b0;
            sp_out_q      <= '0;
        end else begin
            state_q       <= state_d;
            push_q        <= push_d;
            pop_q         <= pop_d;
            sp_q          <= sp_d;
            orig_sp_q     <= orig_sp_d;
            ss_q          <= ss_d;
            cur_idx_q     <= cur_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            reg_sel_q     <= reg_sel_d;
            reg_we_q      <= reg_we_d;
            reg_wr_sel_q  <= reg_wr_sel_d;
            reg_wr_data_q <= reg_wr_data_d;
            mem_req_q     <= mem_req_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            sp_we_q       <= sp_we_d;
            sp_out_q      <= sp_out_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign reg_sel     = reg_sel_q;
    assign reg_we      = reg_we_q;
    assign reg_wr_sel  = reg_wr_sel_q;
    assign reg_wr_data = reg_wr_data_q;
    assign mem_req     = mem_req_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign sp_we       = sp_we_q;
    assign sp_out      = sp_out_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a delayable bus responder and register-file stub.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] push_mask = '0;
    logic [15:0] pop_mask = '0;
    logic [15:0] sp_in = '0;
    logic [15:0] ss_in = '0;
    logic        busy, done, reg_we, mem_req, mem_wr, sp_we;
    logic [3:0]  reg_sel, reg_wr_sel;
    logic [15:0] reg_rdata, reg_wr_data, mem_wdata, sp_out;
    logic [19:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    // Bus responder state and logs.
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic [19:0] h_addr;
    logic        h_wr;
    logic [15:0] h_wdata;
    logic [15:0] mem [int unsigned];
    logic [31:0] tx_addr[$];
    logic [31:0] tx_wr[$];
    logic [31:0] tx_data[$];
    logic [31:0] wb_sel[$];
    logic [31:0] wb_data[$];

    stack_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in), .ss_in(ss_in),
        .busy(busy), .done(done),
        .reg_sel(reg_sel), .reg_rdata(reg_rdata),
        .reg_we(reg_we), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sp_we(sp_we), .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    // Register file stub: each register holds C000 | index.
    assign reg_rdata = 16'hC000 | 16'(reg_sel);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus responder: acks after ack_delay waiting cycles, checks request stability meanwhile.
    always @(negedge clk) begin
        if (mem_req && !reset) begin
            if (wait_cnt == 0) begin
                h_addr  = mem_addr;
                h_wr    = mem_wr;
                h_wdata = mem_wdata;
            end else begin
                check("req_stable_addr", 32'(mem_addr), 32'(h_addr));
                check("req_stable_wr", 32'(mem_wr), 32'(h_wr));
                check("req_stable_wdata", 32'(mem_wdata), 32'(h_wdata));
            end
            if (wait_cnt == ack_delay) begin
                mem_ack = 1'b1;
                tx_addr.push_back(32'(mem_addr));
                tx_wr.push_back(32'(mem_wr));
                tx_data.push_back(32'(mem_wdata));
                if (mem_wr) mem[32'(mem_addr)] = mem_wdata;
                else mem_rdata = mem.exists(32'(mem_addr)) ? mem[32'(mem_addr)] : 16'hDEAD;
                wait_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Write-back monitor.
    always @(negedge clk) begin
        if (reg_we) begin
            wb_sel.push_back(32'(reg_wr_sel));
            wb_data.push_back(32'(reg_wr_data));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({busy, done, reg_we, mem_req, mem_wr, sp_we}), 32'h0);
        check({tag, "_sel"}, 32'({reg_sel, reg_wr_sel}), 32'h0);
        check({tag, "_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_data"}, {mem_wdata, reg_wr_data}, 32'h0);
        check({tag, "_sp_out"}, 32'(sp_out), 32'h0);
    endtask

    // Launch one sequence and wait (bounded) for done. poke_cyc >= 0 pulses start mid-run.
    task automatic run_seq(input logic [15:0] pu, input logic [15:0] po, input logic [15:0] sp,
                           input logic [15:0] ss, input int poke_cyc,
                           output int first_req, output logic [15:0] spo);
        int cyc;
        bit got;
        tx_addr.delete(); tx_wr.delete(); tx_data.delete();
        wb_sel.delete(); wb_data.delete();
        first_req = -1;
        spo = '0;
        got = 1'b0;
        @(negedge clk);
        push_mask = pu; pop_mask = po; sp_in = sp; ss_in = ss; start = 1'b1;
        for (cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == poke_cyc) begin
                push_mask = 16'hFFFF; pop_mask = 16'hFFFF; sp_in = 16'h5555; start = 1'b1;
            end
            if (mem_req && first_req < 0) first_req = cyc;
            if (done) begin
                spo = sp_out;
                check("sp_we_with_done", 32'(sp_we), 32'h1);
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'h1);
        @(negedge clk);
        check("busy_after_fin", 32'(busy), 32'h0);
    endtask

    initial begin
        int          fr;
        logic [15:0] spo;
        int          idx;
        int          k;
        int          bad;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Push 0x00FF at 2000:0100.
        ack_delay = 0;
        run_seq(16'h00FF, 16'h0000, 16'h0100, 16'h2000, -1, fr, spo);
        check("push8_first_req", 32'(fr), 32'd2);
        check("push8_sp_out", 32'(spo), 32'h00F0);
        check("push8_count", 32'(tx_addr.size()), 32'd8);
        for (k = 0; k < 8 && k < tx_addr.size(); k++) begin
            idx = 7 - k;
            check("push8_addr", tx_addr[k], 32'h200FE - 32'(2 * k));
            check("push8_wr", tx_wr[k], 32'h1);
            check("push8_data", tx_data[k], (idx == 4) ? 32'h0100 : (32'hC000 | 32'(idx)));
        end

        // Pop 0x00FF back from 2000:00F0.
        run_seq(16'h0000, 16'h00FF, 16'h00F0, 16'h2000, -1, fr, spo);
        check("pop8_first_req", 32'(fr), 32'd1);
        check("pop8_sp_out", 32'(spo), 32'h0100);
        check("pop8_reads", 32'(tx_addr.size()), 32'd8);
        for (k = 0; k < 8 && k < tx_addr.size(); k++) begin
            check("pop8_addr", tx_addr[k], 32'h200F0 + 32'(2 * k));
            check("pop8_rd", tx_wr[k], 32'h0);
        end
        check("pop8_wb_count", 32'(wb_sel.size()), 32'd7);
        for (k = 0; k < 7 && k < wb_sel.size(); k++) begin
            idx = (k < 4) ? k : k + 1;
            check("pop8_wb_sel", wb_sel[k], 32'(idx));
            check("pop8_wb_data", wb_data[k], 32'hC000 | 32'(idx));
        end

        // Interrupt frame push PC, PS, PSW then restore.
        run_seq(16'h2600, 16'h0000, 16'h0010, 16'h0000, -1, fr, spo);
        check("int_push_sp_out", 32'(spo), 32'h000A);
        check("int_push_count", 32'(tx_addr.size()), 32'd3);
        if (tx_addr.size() == 3) begin
            check("int_pc_addr", tx_addr[0], 32'h0000E);
            check("int_pc_data", tx_data[0], 32'hC00D);
            check("int_ps_addr", tx_addr[1], 32'h0000C);
            check("int_ps_data", tx_data[1], 32'hC00A);
            check("int_psw_addr", tx_addr[2], 32'h0000A);
            check("int_psw_data", tx_data[2], 32'hC009);
        end
        run_seq(16'h0000, 16'h2600, 16'h000A, 16'h0000, -1, fr, spo);
        check("int_pop_sp_out", 32'(spo), 32'h0010);
        check("int_pop_wb_count", 32'(wb_sel.size()), 32'd3);
        if (wb_sel.size() == 3) begin
            check("int_pop_psw", {wb_sel[0][15:0], wb_data[0][15:0]}, {16'd9, 16'hC009});
            check("int_pop_ps", {wb_sel[1][15:0], wb_data[1][15:0]}, {16'd10, 16'hC00A});
            check("int_pop_pc", {wb_sel[2][15:0], wb_data[2][15:0]}, {16'd13, 16'hC00D});
        end

        // Address and SP wrap.
        run_seq(16'h0001, 16'h0000, 16'h0000, 16'hFFFF, -1, fr, spo);
        check("wrap_sp_out", 32'(spo), 32'hFFFE);
        check("wrap_count", 32'(tx_addr.size()), 32'd1);
        if (tx_addr.size() == 1) begin
            check("wrap_addr", tx_addr[0], 32'h0FFEE);
            check("wrap_data", tx_data[0], 32'hC000);
        end

        // Slow ack with a start pulse while busy.
        ack_delay = 3;
        run_seq(16'h0003, 16'h0000, 16'h0200, 16'h1000, 3, fr, spo);
        check("slow_sp_out", 32'(spo), 32'h01FC);
        check("slow_count", 32'(tx_addr.size()), 32'd2);
        if (tx_addr.size() == 2) begin
            check("slow_addr0", tx_addr[0], 32'h101FE);
            check("slow_data0", tx_data[0], 32'hC001);
            check("slow_addr1", tx_addr[1], 32'h101FC);
            check("slow_data1", tx_data[1], 32'hC000);
        end
        repeat (3) @(negedge clk);
        check("slow_no_restart", 32'({busy, mem_req}), 32'h0);

        // Reset in the middle of a slow pop.
        wb_sel.delete();
        @(negedge clk);
        push_mask = 16'h0000; pop_mask = 16'h0001; sp_in = 16'h0300; ss_in = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_req_up", 32'(mem_req), 32'h1);
        reset = 1'b1;
        bad = 0;
        for (k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done || reg_we || mem_req) bad++;
        end
        check("abort_quiet", 32'(bad), 32'h0);
        check("abort_wb_none", 32'(wb_sel.size()), 32'h0);
        check_all_zero("abort");
        reset = 1'b0;

        // Empty masks: done one cycle after start, no bus cycle.
        ack_delay = 0;
        @(negedge clk);
        push_mask = '0; pop_mask = '0; sp_in = 16'h1234; ss_in = 16'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_done", 32'({done, sp_we}), 32'h3);
        check("empty_sp_out", 32'(sp_out), 32'h1234);
        check("empty_no_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        check("empty_after", 32'({done, busy, mem_req}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
